maq_h: RTL and testbench



---
 rtl/maq_h_if.sv | 22 ++
 rtl/maq_h.sv | 85 ++++++++
 tb/tb_maq_h.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/maq_h_if.sv
// rtl/maq_h_if.sv - control and display bundle of the hours stage
interface maq_h_if;
    logic       maqh_enable;
    logic       maqh_carry;
    logic       maqh_set;
    logic       maqh_set_inc;
    logic       maqh_mode12;
    logic [3:0] maqh_Lsd;
    logic [1:0] maqh_Msd;
    logic       maqh_pm;
    logic       maqh_incrementadia;

    modport master (
        output maqh_enable, maqh_carry, maqh_set, maqh_set_inc, maqh_mode12,
        input  maqh_Lsd, maqh_Msd, maqh_pm, maqh_incrementadia
    );

    modport slave (
        input  maqh_enable, maqh_carry, maqh_set, maqh_set_inc, maqh_mode12,
        output maqh_Lsd, maqh_Msd, maqh_pm, maqh_incrementadia
    );
endinterface

// File: rtl/maq_h.sv
// rtl/maq_h.sv - hours counter 0-23 with set mode, 12/24 h BCD display and day pulse
module maq_h #(
    parameter int RESET_HOUR = 0
) (
    input  logic    maqh_clock,
    input  logic    maqh_reset,
    maq_h_if.slave  bus
);
    typedef enum logic {ST_RUN, ST_SET} state_t;

    state_t     state, state_next;
    logic [4:0] h, h_next;
    logic       carry_q, inc_q;
    logic       carry_rise, inc_rise, bump, day_next;
    logic [4:0] disp;
    logic [3:0] lsd_next;
    logic [1:0] msd_next;
    logic       pm_next;

    assign carry_rise = bus.maqh_carry & ~carry_q;
    assign inc_rise   = bus.maqh_set_inc & ~inc_q;

    always_ff @(posedge maqh_clock) begin
        if (maqh_reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Increment rules follow the state held before the edge, not state_next.
    always_comb begin
        state_next = bus.maqh_set ? ST_SET : ST_RUN;
        h_next     = h;
        bump       = bus.maqh_enable & ((state == ST_RUN) ? carry_rise : inc_rise);
        if (bump) begin
            h_next = (h == 5'd23) ? 5'd0 : h + 5'd1;
        end
        day_next = bump & (state == ST_RUN) & (h == 5'd23);
    end

    always_comb begin
        disp    = h;
        pm_next = 1'b0;
        if (bus.maqh_mode12) begin
            pm_next = (h >= 5'd12);
            if (h == 5'd0) begin
                disp = 5'd12;
            end else if (h > 5'd12) begin
                disp = h - 5'd12;
            end
        end
        if (disp >= 5'd20) begin
            msd_next = 2'd2;
            lsd_next = 4'(disp - 5'd20);
        end else if (disp >= 5'd10) begin
            msd_next = 2'd1;
            lsd_next = 4'(disp - 5'd10);
        end else begin
            msd_next = 2'd0;
            lsd_next = 4'(disp);
        end
    end

    // Edge registers reset high so a level already present at release is not a rise.
    always_ff @(posedge maqh_clock) begin
        if (maqh_reset) begin
            h                      <= 5'(RESET_HOUR);
            carry_q                <= 1'b1;
            inc_q                  <= 1'b1;
            bus.maqh_Lsd           <= 4'd0;
            bus.maqh_Msd           <= 2'd0;
            bus.maqh_pm            <= 1'b0;
            bus.maqh_incrementadia <= 1'b0;
        end else begin
            h                      <= h_next;
            carry_q                <= bus.maqh_carry;
            inc_q                  <= bus.maqh_set_inc;
            bus.maqh_Lsd           <= lsd_next;
            bus.maqh_Msd           <= msd_next;
            bus.maqh_pm            <= pm_next;
            bus.maqh_incrementadia <= day_next;
        end
    end
endmodule

// File: tb/tb_maq_h.sv
// tb/tb_maq_h.sv - directed self-checking bench for maq_h
module tb_maq_h;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   inca_cnt = 0;
    logic inca_prev = 1'b0;
    logic consec = 1'b0;
    int   base;

    maq_h_if bus ();

    maq_h #(.RESET_HOUR(0)) dut (
        .maqh_clock (clk),
        .maqh_reset (rst),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.maqh_incrementadia === 1'b1) inca_cnt++;
        if (bus.maqh_incrementadia === 1'b1 && inca_prev) consec = 1'b1;
        inca_prev = (bus.maqh_incrementadia === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] shown();
        return 32'(bus.maqh_Msd) * 10 + 32'(bus.maqh_Lsd);
    endfunction

    task automatic pulse_carry(input int n);
        for (int k = 0; k < n; k++) begin
            bus.maqh_carry = 1'b1;
            tick();
            bus.maqh_carry = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_inc(input int n);
        for (int k = 0; k < n; k++) begin
            bus.maqh_set_inc = 1'b1;
            tick();
            bus.maqh_set_inc = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.maqh_enable  = 1'b1;
        bus.maqh_carry   = 1'b1;
        bus.maqh_set     = 1'b0;
        bus.maqh_set_inc = 1'b0;
        bus.maqh_mode12  = 1'b0;
        repeat (3) tick();
        check("reset_lsd", 32'(bus.maqh_Lsd), 0);
        check("reset_msd", 32'(bus.maqh_Msd), 0);
        check("reset_pm", 32'(bus.maqh_pm), 0);
        check("reset_inca", 32'(bus.maqh_incrementadia), 0);
        rst = 1'b0;
        repeat (5) tick();
        check("held_carry_no_inc", shown(), 0);
        bus.maqh_carry = 1'b0;
        tick();

        // 24 rises held 10 cycles each: 01..23 then 00, one day pulse at the wrap
        base = inca_cnt;
        for (int i = 1; i <= 24; i++) begin
            bus.maqh_carry = 1'b1;
            tick();
            if (i == 24) check("wrap_inca_high", 32'(bus.maqh_incrementadia), 1);
            tick();
            if (i == 24) check("wrap_inca_low", 32'(bus.maqh_incrementadia), 0);
            repeat (8) tick();
            check($sformatf("count_%0d", i), shown(), 32'(i % 24));
            bus.maqh_carry = 1'b0;
            repeat (2) tick();
        end
        check("count_inca_once", 32'(inca_cnt - base), 1);

        bus.maqh_mode12 = 1'b1;
        tick();
        check("m12_h0", shown(), 12);
        check("m12_h0_pm", 32'(bus.maqh_pm), 0);
        pulse_carry(12);
        check("m12_h12", shown(), 12);
        check("m12_h12_pm", 32'(bus.maqh_pm), 1);
        pulse_carry(1);
        check("m12_h13", shown(), 1);
        check("m12_h13_pm", 32'(bus.maqh_pm), 1);
        bus.maqh_mode12 = 1'b0;
        tick();
        check("m24_h13", shown(), 13);
        check("m24_h13_pm", 32'(bus.maqh_pm), 0);
        bus.maqh_mode12 = 1'b1;
        pulse_carry(10);
        check("m12_h23", shown(), 11);
        check("m12_h23_pm", 32'(bus.maqh_pm), 1);
        bus.maqh_mode12 = 1'b0;
        tick();
        check("m24_h23", shown(), 23);

        // reach 22, then set mode wraps 22 -> 1 without a day pulse
        pulse_carry(23);
        check("pre_set_h22", shown(), 22);
        bus.maqh_set = 1'b1;
        tick();
        base = inca_cnt;
        pulse_inc(3);
        check("set_h1", shown(), 1);
        check("set_no_inca", 32'(inca_cnt - base), 0);
        pulse_carry(1);
        check("set_carry_ignored", shown(), 1);
        bus.maqh_set = 1'b0;
        tick();
        pulse_inc(1);
        check("run_inc_ignored", shown(), 1);
        pulse_carry(1);
        check("run_after_set_h2", shown(), 2);

        bus.maqh_enable = 1'b0;
        bus.maqh_carry  = 1'b1;
        repeat (2) tick();
        bus.maqh_enable = 1'b1;
        repeat (2) tick();
        bus.maqh_carry = 1'b0;
        repeat (2) tick();
        check("enable_gating", shown(), 2);

        pulse_carry(21);
        check("pre_reset_h23", shown(), 23);
        bus.maqh_set = 1'b1;
        tick();
        base = inca_cnt;
        rst            = 1'b1;
        bus.maqh_carry = 1'b1;
        tick();
        check("midreset_inca", 32'(bus.maqh_incrementadia), 0);
        check("midreset_disp", shown(), 0);
        rst            = 1'b0;
        bus.maqh_set   = 1'b0;
        bus.maqh_carry = 1'b0;
        repeat (2) tick();
        check("after_reset_h0", shown(), 0);
        check("midreset_no_inca", 32'(inca_cnt - base), 0);
        pulse_inc(1);
        check("after_reset_run", shown(), 0);
        pulse_carry(1);
        check("after_reset_carry", shown(), 1);
        check("inca_never_consecutive", 32'(consec), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
